atm_session_ctrl: RTL and testbench



---
 rtl/atm_pkg.sv | 46 ++++
 rtl/atm_session_ctrl_if.sv | 28 ++
 rtl/atm_account_table.sv | 124 ++++++++++++
 rtl/atm_session_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/atm_pkg.sv
// Shared types for the ATM session controller: opcodes, response codes,
// controller states and the overflow helper used by deposit and transfer.
package atm_pkg;

   typedef enum logic [2:0] {
      OP_LOGIN    = 3'd0,
      OP_BALANCE  = 3'd1,
      OP_WITHDRAW = 3'd2,
      OP_DEPOSIT  = 3'd3,
      OP_TRANSFER = 3'd4,
      OP_LOGOUT   = 3'd5,
      OP_ILL6     = 3'd6,
      OP_ILL7     = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      ST_OK         = 3'd0,
      ST_BAD_AUTH   = 3'd1,
      ST_LOCKED     = 3'd2,
      ST_FUNDS      = 3'd3,
      ST_NO_DEST    = 3'd4,
      ST_OVERFLOW   = 3'd5,
      ST_NO_SESSION = 3'd6,
      ST_ILLEGAL    = 3'd7
   } status_e;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SESSION = 3'd1,
      S_SCAN    = 3'd2,
      S_EXEC    = 3'd3,
      S_RESP    = 3'd4
   } state_e;

   localparam status_e STATUS_OK      = ST_OK;
   localparam status_e STATUS_ILLEGAL = ST_ILLEGAL;

   // True when a + b does not fit in 'width' bits (width up to 32).
   function automatic logic sat_check(input logic [31:0] a, input logic [31:0] b,
                                      input int unsigned width);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return (sum >> width) != 33'd0;
   endfunction

endpackage

// File: rtl/atm_session_ctrl_if.sv
// Request/response channel between the keypad host and the session controller.
interface atm_session_ctrl_if #(
   parameter int ACC_W = 12,
   parameter int PIN_W = 4,
   parameter int BAL_W = 16,
   parameter int AMT_W = 11
);
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_op;
   logic [ACC_W-1:0] acc_num;
   logic [PIN_W-1:0] pin;
   logic [ACC_W-1:0] dest_acc;
   logic [AMT_W-1:0] amount;
   logic             rsp_valid;
   logic [2:0]       rsp_status;
   logic [BAL_W-1:0] rsp_balance;

   modport master (
      output req_valid, req_op, acc_num, pin, dest_acc, amount,
      input  req_ready, rsp_valid, rsp_status, rsp_balance
   );

   modport slave (
      input  req_valid, req_op, acc_num, pin, dest_acc, amount,
      output req_ready, rsp_valid, rsp_status, rsp_balance
   );
endinterface

// File: rtl/atm_account_table.sv
// Account table: number, PIN, valid, balance, PIN-failure count and lock per
// entry. One combinational read port for the scan, two balance read/write
// ports so a transfer can update both sides in one cycle.
module atm_account_table
   import atm_pkg::*;
#(
   parameter int NUM_ACCOUNTS  = 10,
   parameter int ACC_W         = 12,
   parameter int PIN_W         = 4,
   parameter int BAL_W         = 16,
   parameter int INIT_BALANCE  = 500,
   parameter int MAX_PIN_TRIES = 3,
   localparam int IDX_W  = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1,
   localparam int FAIL_W = $clog2(MAX_PIN_TRIES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              prov_we,
   input  logic [IDX_W-1:0]  prov_idx,
   input  logic [ACC_W-1:0]  prov_acc,
   input  logic [PIN_W-1:0]  prov_pin,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [ACC_W-1:0]  rd_acc,
   output logic [PIN_W-1:0]  rd_pin,
   output logic              rd_valid,
   output logic [FAIL_W-1:0] rd_fail,
   output logic              rd_lock,
   input  logic [IDX_W-1:0]  bal_a_idx,
   output logic [BAL_W-1:0]  bal_a,
   input  logic [IDX_W-1:0]  bal_b_idx,
   output logic [BAL_W-1:0]  bal_b,
   input  logic              auth_we,
   input  logic [IDX_W-1:0]  auth_idx,
   input  logic [FAIL_W-1:0] auth_fail,
   input  logic              auth_lock,
   input  logic              wr_a_en,
   input  logic [BAL_W-1:0]  wr_a_bal,
   input  logic              wr_b_en,
   input  logic [BAL_W-1:0]  wr_b_bal
);

   logic [ACC_W-1:0]  acc_q   [NUM_ACCOUNTS];
   logic [ACC_W-1:0]  acc_d   [NUM_ACCOUNTS];
   logic [PIN_W-1:0]  pin_q   [NUM_ACCOUNTS];
   logic [PIN_W-1:0]  pin_d   [NUM_ACCOUNTS];
   logic              valid_q [NUM_ACCOUNTS];
   logic              valid_d [NUM_ACCOUNTS];
   logic [BAL_W-1:0]  bal_q   [NUM_ACCOUNTS];
   logic [BAL_W-1:0]  bal_d   [NUM_ACCOUNTS];
   logic [FAIL_W-1:0] fail_q  [NUM_ACCOUNTS];
   logic [FAIL_W-1:0] fail_d  [NUM_ACCOUNTS];
   logic              lock_q  [NUM_ACCOUNTS];
   logic              lock_d  [NUM_ACCOUNTS];

   function automatic logic in_range(input logic [IDX_W-1:0] i);
      return 32'(i) < NUM_ACCOUNTS;
   endfunction

   // Read ports; indices past the last entry read as an empty slot.
   always_comb begin
      rd_acc   = '0;
      rd_pin   = '0;
      rd_valid = 1'b0;
      rd_fail  = '0;
      rd_lock  = 1'b0;
      bal_a    = '0;
      bal_b    = '0;
      if (in_range(rd_idx)) begin
         rd_acc   = acc_q[rd_idx];
         rd_pin   = pin_q[rd_idx];
         rd_valid = valid_q[rd_idx];
         rd_fail  = fail_q[rd_idx];
         rd_lock  = lock_q[rd_idx];
      end
      if (in_range(bal_a_idx)) bal_a = bal_q[bal_a_idx];
      if (in_range(bal_b_idx)) bal_b = bal_q[bal_b_idx];
   end

   // Next table contents from provisioning, login bookkeeping and balance writes.
   always_comb begin
      acc_d   = acc_q;
      pin_d   = pin_q;
      valid_d = valid_q;
      bal_d   = bal_q;
      fail_d  = fail_q;
      lock_d  = lock_q;
      if (prov_we && in_range(prov_idx)) begin
         acc_d[prov_idx]   = prov_acc;
         pin_d[prov_idx]   = prov_pin;
         valid_d[prov_idx] = 1'b1;
         bal_d[prov_idx]   = BAL_W'(INIT_BALANCE);
         fail_d[prov_idx]  = '0;
         lock_d[prov_idx]  = 1'b0;
      end
      if (auth_we && in_range(auth_idx)) begin
         fail_d[auth_idx] = auth_fail;
         lock_d[auth_idx] = auth_lock;
      end
      if (wr_a_en && in_range(bal_a_idx)) bal_d[bal_a_idx] = wr_a_bal;
      if (wr_b_en && in_range(bal_b_idx)) bal_d[bal_b_idx] = wr_b_bal;
   end

   // Table storage; reset empties every slot and restores opening balances.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            acc_q[i]   <= '0;
            pin_q[i]   <= '0;
            valid_q[i] <= 1'b0;
            bal_q[i]   <= BAL_W'(INIT_BALANCE);
            fail_q[i]  <= '0;
            lock_q[i]  <= 1'b0;
         end
      end else begin
         acc_q   <= acc_d;
         pin_q   <= pin_d;
         valid_q <= valid_d;
         bal_q   <= bal_d;
         fail_q  <= fail_d;
         lock_q  <= lock_d;
      end
   end

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: accepts one request at a time, scans the account
// table for login/transfer lookups, applies one read-modify-write and returns
// a single-cycle response. Idle sessions are logged out after IDLE_CYCLES.
module atm_session_ctrl
   import atm_pkg::*;
#(
   parameter int NUM_ACCOUNTS  = 10,
   parameter int ACC_W         = 12,
   parameter int PIN_W         = 4,
   parameter int BAL_W         = 16,
   parameter int AMT_W         = 11,
   parameter int INIT_BALANCE  = 500,
   parameter int MAX_PIN_TRIES = 3,
   parameter int IDLE_CYCLES   = 6000,
   localparam int IDX_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             prov_we,
   input  logic [IDX_W-1:0] prov_idx,
   input  logic [ACC_W-1:0] prov_acc,
   input  logic [PIN_W-1:0] prov_pin,
   atm_session_ctrl_if.slave bus,
   output logic             session_active,
   output logic             timeout_pulse
);

   localparam int FAIL_W = $clog2(MAX_PIN_TRIES + 1);
   localparam int CNT_W  = $clog2(IDLE_CYCLES + 1);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [ACC_W-1:0] acc_q, acc_d, dest_q, dest_d;
   logic [PIN_W-1:0] pin_q, pin_d;
   logic [AMT_W-1:0] amt_q, amt_d;
   logic [IDX_W-1:0] scan_idx_q, scan_idx_d, match_idx_q, match_idx_d, sess_idx_q, sess_idx_d;
   logic             found_q, found_d;
   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
   logic             req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
   status_e          rsp_status_q, rsp_status_d;
   logic [BAL_W-1:0] rsp_balance_q, rsp_balance_d;
   logic             session_active_q, session_active_d, timeout_pulse_q, timeout_pulse_d;

   logic              hs, prov_en;
   logic [IDX_W-1:0]  rd_idx;
   logic [ACC_W-1:0]  rd_acc, target;
   logic [PIN_W-1:0]  rd_pin;
   logic              rd_valid, rd_lock;
   logic [FAIL_W-1:0] rd_fail, fail_inc, auth_fail;
   logic [BAL_W-1:0]  bal_a, bal_b, amt_ext, wr_a_bal, wr_b_bal;
   logic              auth_we, auth_lock, wr_a_en, wr_b_en;

   assign hs       = bus.req_valid && req_ready_q;
   assign prov_en  = prov_we && (state_q == S_IDLE);
   assign target   = (op_q == OP_TRANSFER) ? dest_q : acc_q;
   assign rd_idx   = (state_q == S_SCAN) ? scan_idx_q : match_idx_q;
   assign amt_ext  = BAL_W'(amt_q);
   assign fail_inc = rd_fail + FAIL_W'(1);

   atm_account_table #(
      .NUM_ACCOUNTS(NUM_ACCOUNTS), .ACC_W(ACC_W), .PIN_W(PIN_W), .BAL_W(BAL_W),
      .INIT_BALANCE(INIT_BALANCE), .MAX_PIN_TRIES(MAX_PIN_TRIES)
   ) u_table (
      .clk(clk), .rst(rst),
      .prov_we(prov_en), .prov_idx(prov_idx), .prov_acc(prov_acc), .prov_pin(prov_pin),
      .rd_idx(rd_idx), .rd_acc(rd_acc), .rd_pin(rd_pin), .rd_valid(rd_valid),
      .rd_fail(rd_fail), .rd_lock(rd_lock),
      .bal_a_idx(sess_idx_q), .bal_a(bal_a), .bal_b_idx(match_idx_q), .bal_b(bal_b),
      .auth_we(auth_we), .auth_idx(match_idx_q), .auth_fail(auth_fail), .auth_lock(auth_lock),
      .wr_a_en(wr_a_en), .wr_a_bal(wr_a_bal), .wr_b_en(wr_b_en), .wr_b_bal(wr_b_bal)
   );

   // Next-state, operation execution and table write controls.
   always_comb begin
      state_d          = state_q;
      op_d             = op_q;
      acc_d            = acc_q;
      dest_d           = dest_q;
      pin_d            = pin_q;
      amt_d            = amt_q;
      scan_idx_d       = scan_idx_q;
      match_idx_d      = match_idx_q;
      sess_idx_d       = sess_idx_q;
      found_d          = found_q;
      idle_cnt_d       = idle_cnt_q;
      rsp_valid_d      = 1'b0;
      rsp_status_d     = rsp_status_q;
      rsp_balance_d    = rsp_balance_q;
      session_active_d = session_active_q;
      timeout_pulse_d  = 1'b0;
      auth_we          = 1'b0;
      auth_fail        = '0;
      auth_lock        = 1'b0;
      wr_a_en          = 1'b0;
      wr_a_bal         = '0;
      wr_b_en          = 1'b0;
      wr_b_bal         = '0;
      case (state_q)
         S_IDLE, S_SESSION: begin
            if (hs) begin
               op_d        = op_e'(bus.req_op);
               acc_d       = bus.acc_num;
               pin_d       = bus.pin;
               dest_d      = bus.dest_acc;
               amt_d       = bus.amount;
               idle_cnt_d  = '0;
               scan_idx_d  = '0;
               match_idx_d = '0;
               found_d     = 1'b0;
               state_d     = (op_e'(bus.req_op) == OP_LOGIN || op_e'(bus.req_op) == OP_TRANSFER)
                             ? S_SCAN : S_EXEC;
            end else if (state_q == S_SESSION) begin
               if (idle_cnt_q == CNT_W'(IDLE_CYCLES - 1)) begin
                  timeout_pulse_d  = 1'b1;
                  session_active_d = 1'b0;
                  idle_cnt_d       = '0;
                  state_d          = S_IDLE;
               end else begin
                  idle_cnt_d = idle_cnt_q + CNT_W'(1);
               end
            end
         end
         S_SCAN: begin
            if (!found_q && rd_valid && rd_acc == target) begin
               found_d     = 1'b1;
               match_idx_d = scan_idx_q;
            end
            if (scan_idx_q == IDX_W'(NUM_ACCOUNTS - 1)) state_d = S_EXEC;
            else scan_idx_d = scan_idx_q + IDX_W'(1);
         end
         S_EXEC: begin
            state_d       = S_RESP;
            rsp_balance_d = session_active_q ? bal_a : '0;
            if (op_q == OP_ILL6 || op_q == OP_ILL7) begin
               rsp_status_d = STATUS_ILLEGAL;
            end else if (op_q == OP_LOGIN) begin
               if (session_active_q) begin
                  rsp_status_d = STATUS_ILLEGAL;
               end else if (!found_q) begin
                  rsp_status_d = ST_BAD_AUTH;
               end else if (rd_lock) begin
                  rsp_status_d = ST_LOCKED;
               end else if (rd_pin != pin_q) begin
                  rsp_status_d = ST_BAD_AUTH;
                  auth_we      = 1'b1;
                  auth_fail    = fail_inc;
                  auth_lock    = (fail_inc == FAIL_W'(MAX_PIN_TRIES));
               end else begin
                  rsp_status_d     = STATUS_OK;
                  auth_we          = 1'b1;
                  sess_idx_d       = match_idx_q;
                  session_active_d = 1'b1;
                  rsp_balance_d    = bal_b;
               end
            end else if (!session_active_q) begin
               rsp_status_d = ST_NO_SESSION;
            end else begin
               case (op_q)
                  OP_WITHDRAW: begin
                     if (amt_ext > bal_a) begin
                        rsp_status_d = ST_FUNDS;
                     end else begin
                        rsp_status_d  = STATUS_OK;
                        wr_a_en       = 1'b1;
                        wr_a_bal      = bal_a - amt_ext;
                        rsp_balance_d = wr_a_bal;
                     end
                  end
                  OP_DEPOSIT: begin
                     if (sat_check(32'(bal_a), 32'(amt_ext), BAL_W)) begin
                        rsp_status_d = ST_OVERFLOW;
                     end else begin
                        rsp_status_d  = STATUS_OK;
                        wr_a_en       = 1'b1;
                        wr_a_bal      = bal_a + amt_ext;
                        rsp_balance_d = wr_a_bal;
                     end
                  end
                  OP_TRANSFER: begin
                     if (!found_q || match_idx_q == sess_idx_q) begin
                        rsp_status_d = ST_NO_DEST;
                     end else if (amt_ext > bal_a) begin
                        rsp_status_d = ST_FUNDS;
                     end else if (sat_check(32'(bal_b), 32'(amt_ext), BAL_W)) begin
                        rsp_status_d = ST_OVERFLOW;
                     end else begin
                        rsp_status_d  = STATUS_OK;
                        wr_a_en       = 1'b1;
                        wr_a_bal      = bal_a - amt_ext;
                        wr_b_en       = 1'b1;
                        wr_b_bal      = bal_b + amt_ext;
                        rsp_balance_d = wr_a_bal;
                     end
                  end
                  OP_LOGOUT: begin
                     rsp_status_d     = STATUS_OK;
                     session_active_d = 1'b0;
                     rsp_balance_d    = '0;
                  end
                  default: rsp_status_d = STATUS_OK;
               endcase
            end
         end
         S_RESP: begin
            rsp_valid_d = 1'b1;
            state_d     = session_active_q ? S_SESSION : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      req_ready_d = (state_d == S_IDLE) || (state_d == S_SESSION);
   end

   // Controller registers; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_IDLE;
         op_q             <= OP_LOGIN;
         acc_q            <= '0;
         dest_q           <= '0;
         pin_q            <= '0;
         amt_q            <= '0;
         scan_idx_q       <= '0;
         match_idx_q      <= '0;
         sess_idx_q       <= '0;
         found_q          <= 1'b0;
         idle_cnt_q       <= '0;
         req_ready_q      <= 1'b1;
         rsp_valid_q      <= 1'b0;
         rsp_status_q     <= STATUS_OK;
         rsp_balance_q    <= '0;
         session_active_q <= 1'b0;
         timeout_pulse_q  <= 1'b0;
      end else begin
         state_q          <= state_d;
         op_q             <= op_d;
         acc_q            <= acc_d;
         dest_q           <= dest_d;
         pin_q            <= pin_d;
         amt_q            <= amt_d;
         scan_idx_q       <= scan_idx_d;
         match_idx_q      <= match_idx_d;
         sess_idx_q       <= sess_idx_d;
         found_q          <= found_d;
         idle_cnt_q       <= idle_cnt_d;
         req_ready_q      <= req_ready_d;
         rsp_valid_q      <= rsp_valid_d;
         rsp_status_q     <= rsp_status_d;
         rsp_balance_q    <= rsp_balance_d;
         session_active_q <= session_active_d;
         timeout_pulse_q  <= timeout_pulse_d;
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_status  = rsp_status_q;
   assign bus.rsp_balance = rsp_balance_q;
   assign session_active  = session_active_q;
   assign timeout_pulse   = timeout_pulse_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: directed requests push their expected response
// into a queue; a monitor pops and checks each rsp_valid strobe.
module tb_atm_session_ctrl;
   import atm_pkg::*;

   localparam int NUM_ACCOUNTS  = 10;
   localparam int ACC_W         = 12;
   localparam int PIN_W         = 4;
   localparam int BAL_W         = 16;
   localparam int AMT_W         = 16;
   localparam int INIT_BALANCE  = 500;
   localparam int MAX_PIN_TRIES = 3;
   localparam int IDLE_CYCLES   = 6000;
   localparam int IDX_W         = $clog2(NUM_ACCOUNTS);

   typedef struct {
      string name;
      int    status;
      int    balance;
      int    sess;
      int    lat;
      int    hs_cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             prov_we;
   logic [IDX_W-1:0] prov_idx;
   logic [ACC_W-1:0] prov_acc;
   logic [PIN_W-1:0] prov_pin;
   logic             session_active;
   logic             timeout_pulse;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_rsp_cyc = 0;

   atm_session_ctrl_if #(.ACC_W(ACC_W), .PIN_W(PIN_W), .BAL_W(BAL_W), .AMT_W(AMT_W)) bus ();

   atm_session_ctrl #(
      .NUM_ACCOUNTS(NUM_ACCOUNTS), .ACC_W(ACC_W), .PIN_W(PIN_W), .BAL_W(BAL_W),
      .AMT_W(AMT_W), .INIT_BALANCE(INIT_BALANCE), .MAX_PIN_TRIES(MAX_PIN_TRIES),
      .IDLE_CYCLES(IDLE_CYCLES)
   ) dut (
      .clk(clk), .rst(rst),
      .prov_we(prov_we), .prov_idx(prov_idx), .prov_acc(prov_acc), .prov_pin(prov_pin),
      .bus(bus),
      .session_active(session_active), .timeout_pulse(timeout_pulse)
   );

   always #5 clk = ~clk;

   // Cycle count of rising edges, used to measure response latency.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int required);
      checks++;
      if (actual != required) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
      end
   endtask

   // Response monitor: every strobe must match the oldest expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (bus.rsp_valid) begin
         last_rsp_cyc = cyc;
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_rsp", int'(bus.rsp_valid), 0);
         end else begin
            e = exp_q.pop_front();
            checkOutput({e.name, "_status"}, int'(bus.rsp_status), e.status);
            checkOutput({e.name, "_balance"}, int'(bus.rsp_balance), e.balance);
            checkOutput({e.name, "_session"}, int'(session_active), e.sess);
            checkOutput({e.name, "_latency"}, cyc - e.hs_cyc, e.lat);
         end
      end
   end

   task automatic provision(input int idx, input int acc, input int pinv);
      prov_we  = 1'b1;
      prov_idx = IDX_W'(idx);
      prov_acc = ACC_W'(acc);
      prov_pin = PIN_W'(pinv);
      @(negedge clk);
      prov_we  = 1'b0;
   endtask

   // Issue one request at a negedge and wait for its response to be consumed.
   task automatic applyStimulus(input string name, input int op, input int acc, input int pinv,
                                input int dest, input int amt, input int exp_status,
                                input int exp_bal, input int exp_sess);
      exp_t e;
      int   waited;
      waited = 0;
      while (!bus.req_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checkOutput({name, "_ready"}, int'(bus.req_ready), 1);
      if (!bus.req_ready) return;
      bus.req_valid = 1'b1;
      bus.req_op    = 3'(op);
      bus.acc_num   = ACC_W'(acc);
      bus.pin       = PIN_W'(pinv);
      bus.dest_acc  = ACC_W'(dest);
      bus.amount    = AMT_W'(amt);
      e.name    = name;
      e.status  = exp_status;
      e.balance = exp_bal;
      e.sess    = exp_sess;
      e.lat     = (op == OP_LOGIN || op == OP_TRANSFER) ? NUM_ACCOUNTS + 2 : 2;
      e.hs_cyc  = cyc + 1;
      exp_q.push_back(e);
      @(negedge clk);
      bus.req_valid = 1'b0;
      waited = 0;
      while (exp_q.size() != 0 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      checkOutput({name, "_pending"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Hard stop in case something wedges the simulation.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int pulses;
      int pulse_cyc;
      int login_cyc;
      rst = 1'b1;
      prov_we = 1'b0; prov_idx = '0; prov_acc = '0; prov_pin = '0;
      bus.req_valid = 1'b0; bus.req_op = '0; bus.acc_num = '0;
      bus.pin = '0; bus.dest_acc = '0; bus.amount = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      checkOutput("rst_req_ready", int'(bus.req_ready), 1);
      checkOutput("rst_rsp_valid", int'(bus.rsp_valid), 0);
      checkOutput("rst_rsp_status", int'(bus.rsp_status), 0);
      checkOutput("rst_rsp_balance", int'(bus.rsp_balance), 0);
      checkOutput("rst_session", int'(session_active), 0);
      checkOutput("rst_timeout", int'(timeout_pulse), 0);

      provision(0, 2749, 0);
      provision(1, 2175, 1);

      applyStimulus("login_a",      OP_LOGIN,    2749, 0, 0,    0,     ST_OK,         500, 1);
      applyStimulus("wd_200",       OP_WITHDRAW, 0,    0, 0,    200,   ST_OK,         300, 1);
      applyStimulus("wd_400",       OP_WITHDRAW, 0,    0, 0,    400,   ST_FUNDS,      300, 1);
      applyStimulus("dep_ovf",      OP_DEPOSIT,  0,    0, 0,    65300, ST_OVERFLOW,   300, 1);
      applyStimulus("bal_a",        OP_BALANCE,  0,    0, 0,    0,     ST_OK,         300, 1);
      applyStimulus("login_in_ses", OP_LOGIN,    2175, 1, 0,    0,     ST_ILLEGAL,    300, 1);
      applyStimulus("op6",          6,           0,    0, 0,    0,     ST_ILLEGAL,    300, 1);
      applyStimulus("xfer_100",     OP_TRANSFER, 0,    0, 2175, 100,   ST_OK,         200, 1);
      applyStimulus("logout_a",     OP_LOGOUT,   0,    0, 0,    0,     ST_OK,         0,   0);
      applyStimulus("bal_idle",     OP_BALANCE,  0,    0, 0,    0,     ST_NO_SESSION, 0,   0);
      applyStimulus("login_b",      OP_LOGIN,    2175, 1, 0,    0,     ST_OK,         600, 1);
      applyStimulus("xfer_nodest",  OP_TRANSFER, 0,    0, 9999, 10,    ST_NO_DEST,    600, 1);
      applyStimulus("xfer_self",    OP_TRANSFER, 0,    0, 2175, 10,    ST_NO_DEST,    600, 1);
      applyStimulus("xfer_funds",   OP_TRANSFER, 0,    0, 2749, 700,   ST_FUNDS,      600, 1);
      applyStimulus("dep_50",       OP_DEPOSIT,  0,    0, 0,    50,    ST_OK,         650, 1);
      applyStimulus("logout_b",     OP_LOGOUT,   0,    0, 0,    0,     ST_OK,         0,   0);

      for (int i = 0; i < MAX_PIN_TRIES; i++)
         applyStimulus("bad_pin",   OP_LOGIN,    2749, 5, 0,    0,     ST_BAD_AUTH,   0,   0);
      applyStimulus("locked",       OP_LOGIN,    2749, 0, 0,    0,     ST_LOCKED,     0,   0);
      applyStimulus("no_acct",      OP_LOGIN,    9999, 0, 0,    0,     ST_BAD_AUTH,   0,   0);
      provision(0, 2749, 0);
      applyStimulus("reprov_login", OP_LOGIN,    2749, 0, 0,    0,     ST_OK,         500, 1);

      login_cyc = last_rsp_cyc;
      pulses = 0;
      pulse_cyc = -1;
      for (int i = 0; i < IDLE_CYCLES + 20; i++) begin
         @(negedge clk);
         if (timeout_pulse) begin
            pulses++;
            pulse_cyc = cyc;
         end
      end
      checkOutput("timeout_count", pulses, 1);
      checkOutput("timeout_cycle", pulse_cyc - login_cyc, IDLE_CYCLES);
      checkOutput("timeout_session", int'(session_active), 0);
      applyStimulus("bal_after_to", OP_BALANCE,  0,    0, 0,    0,     ST_NO_SESSION, 0,   0);

      applyStimulus("login_pre_rst", OP_LOGIN,   2749, 0, 0,    0,     ST_OK,         500, 1);
      bus.req_valid = 1'b1;
      bus.req_op    = 3'(OP_TRANSFER);
      bus.dest_acc  = ACC_W'(2175);
      bus.amount    = AMT_W'(50);
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_req_ready", int'(bus.req_ready), 1);
      checkOutput("abort_session", int'(session_active), 0);
      checkOutput("abort_rsp_balance", int'(bus.rsp_balance), 0);
      repeat (NUM_ACCOUNTS + 6) @(negedge clk);
      applyStimulus("login_cleared", OP_LOGIN,   2749, 0, 0,    0,     ST_BAD_AUTH,   0,   0);
      provision(0, 2749, 0);
      provision(1, 2175, 1);
      applyStimulus("login_b_rst",  OP_LOGIN,    2175, 1, 0,    0,     ST_OK,         500, 1);

      checkOutput("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
